cellrv32_bus_monitor: RTL and testbench

//  Multi-channel successor of the single-bus keeper: watches NUM_CH processor-internal bus ports in parallel.
//  Per-channel response timeout with a runtime-programmable limit; each channel terminates on error/timeout/ack.

---
 rtl/cellrv32_bus_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_cellrv32_bus_monitor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_bus_monitor.sv
// Multi-channel bus monitor: per-channel response timeout, first-fault log and fault counter.
// Optional fault interrupt enabled by defining CELLRV32_BUSMON_IRQ_EN.
module cellrv32_bus_monitor #(
    parameter int          NUM_CH      = 2,
    parameter int          TMO_WIDTH   = 8,
    parameter int          TMO_DEFAULT = 15,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFFFF78
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [32*NUM_CH-1:0] bus_addr_i,
    input  logic [NUM_CH-1:0]    bus_rden_i,
    input  logic [NUM_CH-1:0]    bus_wren_i,
    input  logic [NUM_CH-1:0]    bus_ack_i,
    input  logic [NUM_CH-1:0]    bus_err_i,
    input  logic [NUM_CH-1:0]    bus_tmo_i,
    input  logic [NUM_CH-1:0]    bus_ign_i,
    input  logic [31:0]          addr_i,
    input  logic                 rden_i,
    input  logic                 wren_i,
    input  logic [31:0]          data_i,
    output logic [31:0]          data_o,
    output logic                 ack_o,
    output logic [NUM_CH-1:0]    err_o,
    output logic                 irq_o
);

    localparam logic [TMO_WIDTH-1:0] TMO_MIN = TMO_WIDTH'(2);
    localparam logic [TMO_WIDTH-1:0] TMO_ONE = TMO_WIDTH'(1);
    localparam logic [TMO_WIDTH-1:0] TMO_RST = TMO_WIDTH'(TMO_DEFAULT);
    localparam logic [15:0]          CNT_MAX = 16'hFFFF;

    typedef enum logic {S_IDLE, S_PENDING} ch_state_t;

    ch_state_t            r_state [NUM_CH];
    logic [TMO_WIDTH-1:0] r_cnt   [NUM_CH];
    logic [31:0]          r_addr  [NUM_CH];
    logic [NUM_CH-1:0]    r_ign;
    logic [NUM_CH-1:0]    r_err;

    logic [TMO_WIDTH-1:0] r_tmo;
    logic                 r_flag;
    logic                 r_ftype;
    logic [2:0]           r_fch;
    logic [31:0]          r_faddr;
    logic [15:0]          r_count;
    logic                 r_ack;
    logic [31:0]          r_rdata;

    logic [NUM_CH-1:0]    w_dev_flt;
    logic [NUM_CH-1:0]    w_tmo_flt;
    logic [NUM_CH-1:0]    w_flt;
    logic                 w_hit, w_rd, w_wr, w_ctrl_clr, w_count_clr;
    logic [1:0]           w_word;
    logic [31:0]          w_rdata;
    logic                 w_flag_nxt, w_capture, w_cap_type;
    logic [2:0]           w_cap_ch;
    logic [31:0]          w_cap_addr;
    logic [3:0]           w_nflt;
    logic [16:0]          w_count_sum;
    logic [15:0]          w_count_nxt;
    logic [TMO_WIDTH-1:0] w_tmo_wdata;
    logic                 w_irq_en;
    logic                 w_unused;

    assign w_hit       = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign w_word      = addr_i[3:2];
    assign w_rd        = w_hit & rden_i;
    assign w_wr        = w_hit & wren_i;
    assign w_ctrl_clr  = (w_rd | w_wr) && (w_word == 2'd0);
    assign w_count_clr = w_wr && (w_word == 2'd3);
    assign w_tmo_wdata = (data_i[TMO_WIDTH-1:0] < TMO_MIN) ? TMO_MIN : data_i[TMO_WIDTH-1:0];
    assign w_unused    = ^{addr_i[1:0], data_i};

    // Device error outranks timeout on the same channel; an expired counter only counts when not ignored.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        w_dev_flt = '0;
        w_tmo_flt = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (r_state[n] == S_PENDING) begin
                w_dev_flt[n] = bus_err_i[n];
                w_tmo_flt[n] = !bus_err_i[n] &&
                               (((r_cnt[n] == '0) && !r_ign[n]) || bus_tmo_i[n]);
            end
        end
    end
    assign w_flt = w_dev_flt | w_tmo_flt;

    // Downward scan so the lowest-index faulting channel is the one captured.
    always_comb begin
        w_nflt     = '0;
        w_cap_ch   = '0;
        w_cap_type = 1'b0;
        w_cap_addr = '0;
        for (int n = NUM_CH - 1; n >= 0; n--) begin
            if (w_flt[n]) begin
                w_nflt     = w_nflt + 4'd1;
                w_cap_ch   = 3'(n);
                w_cap_type = w_tmo_flt[n];
                w_cap_addr = r_addr[n];
            end
        end
        w_count_sum = {1'b0, (w_count_clr ? 16'd0 : r_count)} + 17'(w_nflt);
        w_count_nxt = w_count_sum[16] ? CNT_MAX : w_count_sum[15:0];
    end

    assign w_capture  = (|w_flt) && (!r_flag || w_ctrl_clr);
    assign w_flag_nxt = (|w_flt) | (r_flag & ~w_ctrl_clr);

    always_comb begin
        w_rdata = '0;
        case (w_word)
            2'd0:    w_rdata = {r_flag, w_irq_en, 11'd0, r_fch, 15'd0, r_ftype};
            2'd1:    w_rdata = r_faddr;
            2'd2:    w_rdata = 32'(r_tmo);
            default: w_rdata = {16'd0, r_count};
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: the per-channel arrays are reset too, so a reset mid-access drops straight to IDLE.
            for (int n = 0; n < NUM_CH; n++) begin
                r_state[n] <= S_IDLE;
                r_cnt[n]   <= '0;
                r_addr[n]  <= '0;
            end
            r_ign <= '0;
            r_err <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every channel sees the same pre-edge state.
            r_err <= w_flt;
            for (int n = 0; n < NUM_CH; n++) begin
                case (r_state[n])
                    S_IDLE: begin
                        r_cnt[n] <= r_tmo - TMO_ONE;
                        r_ign[n] <= 1'b0;
                        if (bus_rden_i[n] | bus_wren_i[n]) begin
                            r_state[n] <= S_PENDING;
                            r_addr[n]  <= bus_addr_i[32*n +: 32];
                        end
                    end
                    default: begin
                        if (r_cnt[n] != '0) r_cnt[n] <= r_cnt[n] - TMO_ONE;
                        r_ign[n] <= r_ign[n] | bus_ign_i[n];
                        if (w_flt[n] || bus_ack_i[n]) r_state[n] <= S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_tmo   <= TMO_RST;
            r_flag  <= 1'b0;
            r_ftype <= 1'b0;
            r_fch   <= '0;
            r_faddr <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_rd | w_wr;
            r_rdata <= w_rd ? w_rdata : '0;
            r_flag  <= w_flag_nxt;
            r_count <= w_count_nxt;
            if (w_capture) begin
                r_fch   <= w_cap_ch;
                r_ftype <= w_cap_type;
                r_faddr <= w_cap_addr;
            end
            if (w_wr && (w_word == 2'd2)) r_tmo <= w_tmo_wdata;
        end
    end

`ifdef CELLRV32_BUSMON_IRQ_EN
    logic r_irq_en;
    logic r_irq;
    logic w_irq_en_nxt;

    assign w_irq_en_nxt = (w_wr && (w_word == 2'd0)) ? data_i[30] : r_irq_en;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= w_flag_nxt & w_irq_en_nxt;
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq_o    = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign irq_o    = 1'b0;
`endif

    assign err_o  = r_err;
    assign ack_o  = r_ack;
    assign data_o = r_rdata;

endmodule

// File: tb/tb_cellrv32_bus_monitor.sv
// Self-checking bench for cellrv32_bus_monitor: directed scenarios plus random traffic vs. a cycle model.
`timescale 1ns/1ps
module tb_cellrv32_bus_monitor;

    localparam int          NUM_CH = 2;
    localparam int          TMO_W  = 8;
    localparam logic [31:0] BASE   = 32'hFFFFFF78;
`ifdef CELLRV32_BUSMON_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic [32*NUM_CH-1:0] bus_addr_i;
    logic [NUM_CH-1:0]    bus_rden_i, bus_wren_i, bus_ack_i, bus_err_i, bus_tmo_i, bus_ign_i;
    logic [31:0]          addr_i, data_i, data_o;
    logic                 rden_i, wren_i, ack_o, irq_o;
    logic [NUM_CH-1:0]    err_o;

    int total = 0;
    int bad   = 0;

    cellrv32_bus_monitor #(
        .NUM_CH(NUM_CH), .TMO_WIDTH(TMO_W), .TMO_DEFAULT(15), .BASE_ADDR(BASE)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .bus_addr_i(bus_addr_i), .bus_rden_i(bus_rden_i), .bus_wren_i(bus_wren_i),
        .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_tmo_i(bus_tmo_i), .bus_ign_i(bus_ign_i),
        .addr_i(addr_i), .rden_i(rden_i), .wren_i(wren_i), .data_i(data_i),
        .data_o(data_o), .ack_o(ack_o), .err_o(err_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each busy channel tracks how many pending cycles it has spent (k) and the
    // limit in force when it started; it times out once k reaches that limit unless ignored earlier.
    bit          m_busy [NUM_CH];
    int          m_k    [NUM_CH];
    int          m_lim  [NUM_CH];
    bit          m_ignd [NUM_CH];
    logic [31:0] m_addr [NUM_CH];
    int          m_tmo, m_count, m_fch;
    bit          m_flag, m_irqen, m_ftype;
    logic [31:0] m_faddr;

    logic [NUM_CH-1:0] exp_err;
    bit                exp_ack, exp_irq;
    logic [31:0]       exp_data;

    task automatic model_reset();
        for (int n = 0; n < NUM_CH; n++) begin
            m_busy[n] = 0; m_k[n] = 0; m_lim[n] = 0; m_ignd[n] = 0; m_addr[n] = '0;
        end
        m_tmo = 15; m_count = 0; m_fch = 0; m_flag = 0; m_irqen = 0; m_ftype = 0; m_faddr = '0;
    endtask

    task automatic model_step();
        bit hit, rd, wr, clr, dev, tmo, old_flag, first_type;
        int w, nflt, first, base, v;
        logic [31:0] first_addr;
        hit = ((addr_i >> 4) == (BASE >> 4));
        w   = int'(addr_i[3:2]);
        rd  = hit && rden_i;
        wr  = hit && wren_i;
        exp_ack  = rd || wr;
        exp_data = '0;
        if (rd) begin
            case (w)
                0: exp_data = {m_flag, m_irqen, 11'd0, 3'(m_fch), 15'd0, m_ftype};
                1: exp_data = m_faddr;
                2: exp_data = 32'(m_tmo);
                default: exp_data = 32'(m_count);
            endcase
        end
        nflt = 0; first = -1; first_type = 0; first_addr = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            exp_err[n] = 1'b0;
            if (m_busy[n]) begin
                dev = bus_err_i[n];
                tmo = !dev && (((m_k[n] >= m_lim[n]) && !m_ignd[n]) || bus_tmo_i[n]);
                if (dev || tmo) begin
                    exp_err[n] = 1'b1;
                    nflt++;
                    if (first < 0) begin first = n; first_type = tmo; first_addr = m_addr[n]; end
                    m_busy[n] = 0;
                end else if (bus_ack_i[n]) begin
                    m_busy[n] = 0;
                end else begin
                    m_k[n]++;
                    m_ignd[n] = m_ignd[n] | bus_ign_i[n];
                end
            end else if (bus_rden_i[n] || bus_wren_i[n]) begin
                m_busy[n] = 1; m_k[n] = 1; m_lim[n] = m_tmo; m_ignd[n] = 0;
                m_addr[n] = bus_addr_i[32*n +: 32];
            end
        end
        clr = (rd || wr) && (w == 0);
        old_flag = m_flag;
        if (wr && w == 0 && IRQ_BUILD) m_irqen = data_i[30];
        if (wr && w == 2) begin
            v = int'(data_i[TMO_W-1:0]);
            m_tmo = (v < 2) ? 2 : v;
        end
        base = (wr && w == 3) ? 0 : m_count;
        m_count = (base + nflt > 65535) ? 65535 : base + nflt;
        if (nflt > 0) begin
            if (!old_flag || clr) begin m_fch = first; m_ftype = first_type; m_faddr = first_addr; end
            m_flag = 1;
        end else if (clr) begin
            m_flag = 0;
        end
        exp_irq = IRQ_BUILD && m_flag && m_irqen;
    endtask

    task automatic step();
        model_step();
        @(posedge clk_i);
        #1;
        check("err_o",  32'(err_o), 32'(exp_err));
        check("ack_o",  32'(ack_o), 32'(exp_ack));
        check("data_o", data_o, exp_data);
        check("irq_o",  32'(irq_o), 32'(exp_irq));
    endtask

    function automatic logic [31:0] haddr(input int w);
        return (BASE & 32'hFFFF_FFF0) | (32'(w) << 2);
    endfunction

    task automatic idle_inputs();
        bus_addr_i = '0; bus_rden_i = '0; bus_wren_i = '0; bus_ack_i = '0;
        bus_err_i = '0; bus_tmo_i = '0; bus_ign_i = '0;
        addr_i = '0; rden_i = 0; wren_i = 0; data_i = '0;
    endtask

    task automatic host_rd(input int w, output logic [31:0] d);
        addr_i = haddr(w); rden_i = 1; step(); d = data_o; rden_i = 0;
    endtask

    task automatic host_wr(input int w, input logic [31:0] v);
        addr_i = haddr(w); wren_i = 1; data_i = v; step(); wren_i = 0; data_i = '0;
    endtask

    task automatic do_reset();
        rstn_i = 0;
        repeat (3) @(posedge clk_i);
        #3;
        check("rst_err_o",  32'(err_o), 32'd0);
        check("rst_ack_o",  32'(ack_o), 32'd0);
        check("rst_data_o", data_o, 32'd0);
        check("rst_irq_o",  32'(irq_o), 32'd0);
        rstn_i = 1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]       d;
        logic [NUM_CH-1:0] errs;
        int                seen;
        idle_inputs();
        do_reset();

        // Plain read acknowledged after 3 cycles: no fault.
        bus_rden_i[0] = 1; step(); bus_rden_i[0] = 0;
        step(); step();
        bus_ack_i[0] = 1; step(); bus_ack_i[0] = 0;
        host_rd(0, d); check("ack_ctrl", d, 32'h0);
        host_rd(3, d); check("ack_count", d, 32'h0);
        host_rd(2, d); check("tmo_default", d, 32'd15);

        // Timeout on ch1 with TMO=4.
        host_wr(2, 32'd4);
        bus_addr_i[63:32] = 32'h80001234; bus_wren_i[1] = 1; step(); bus_wren_i[1] = 0;
        bus_addr_i = '0;
        seen = 0;
        for (int i = 2; i <= 20 && seen == 0; i++) begin
            step();
            if (err_o[1]) seen = i;
        end
        check("tmo_latency", 32'(seen), 32'd5);
        host_rd(1, d); check("tmo_faddr", d, 32'h80001234);
        host_rd(3, d); check("tmo_count", d, 32'd1);
        host_rd(0, d); check("tmo_ctrl", d, 32'h80010001);

        // Ch0 device error and ch1 expiry in the same cycle.
        host_wr(3, 32'd0);
        bus_addr_i = {32'h2000_0004, 32'h1000_0000};
        bus_rden_i[0] = 1; bus_wren_i[1] = 1; step(); bus_rden_i = '0; bus_wren_i = '0;
        step(); step(); step();
        bus_err_i[0] = 1; step(); bus_err_i[0] = 0;
        check("dual_err_o", 32'(err_o), 32'h3);
        host_rd(0, d); check("dual_ctrl", d, 32'h80000000);
        host_rd(1, d); check("dual_faddr", d, 32'h10000000);
        host_rd(3, d); check("dual_count", d, 32'd2);

        // Ignored access waits 100 cycles, then an external timeout fires.
        bus_addr_i[31:0] = 32'h0000_1000; bus_rden_i[0] = 1; step(); bus_rden_i[0] = 0;
        bus_ign_i[0] = 1; step(); bus_ign_i[0] = 0;
        errs = '0;
        for (int i = 0; i < 100; i++) begin step(); errs |= err_o; end
        check("ign_no_err", 32'(errs), 32'h0);
        bus_tmo_i[0] = 1; step(); bus_tmo_i[0] = 0;
        check("ign_tmo_err", 32'(err_o), 32'h1);
        host_rd(1, d); check("ign_faddr", d, 32'h00001000);

        // Second fault with the flag still set keeps the first log entry.
        bus_addr_i[63:32] = 32'hDEAD_0000; bus_wren_i[1] = 1; step(); bus_wren_i[1] = 0;
        bus_err_i[1] = 1; step(); bus_err_i[1] = 0;
        check("second_err_o", 32'(err_o), 32'h2);
        host_rd(1, d); check("second_faddr", d, 32'h00001000);
        host_rd(3, d); check("second_count", d, 32'd4);
        host_rd(0, d); check("second_ctrl", d, 32'h80000001);
        host_rd(0, d); check("ctrl_cleared", d, 32'h00000001);
        host_wr(2, 32'd1);          host_rd(2, d); check("tmo_clamp1", d, 32'd2);
        host_wr(2, 32'd0);          host_rd(2, d); check("tmo_clamp0", d, 32'd2);
        host_wr(2, 32'hFFFF_FF07);  host_rd(2, d); check("tmo_lowbits", d, 32'd7);

        // Interrupt: level until CTRL is read.
        host_wr(0, 32'h4000_0000);
        bus_rden_i[0] = 1; step(); bus_rden_i[0] = 0;
        bus_err_i[0] = 1; step(); bus_err_i[0] = 0;
        check("irq_set", 32'(irq_o), 32'(IRQ_BUILD));
        step();
        check("irq_hold", 32'(irq_o), 32'(IRQ_BUILD));
        host_rd(0, d); check("irq_ctrl", d, IRQ_BUILD ? 32'hC0000000 : 32'h80000000);
        check("irq_clear", 32'(irq_o), 32'd0);
        host_wr(0, 32'd0);

        // Reset in the middle of a pending access.
        bus_rden_i[1] = 1; step(); bus_rden_i[1] = 0;
        step();
        #2;
        do_reset();
        repeat (20) step();
        host_rd(0, d); check("post_rst_ctrl", d, 32'h0);
        host_rd(2, d); check("post_rst_tmo", d, 32'd15);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int r, w;
            for (int n = 0; n < NUM_CH; n++) begin
                bus_addr_i[32*n +: 32] = $urandom;
                bus_rden_i[n] = ($urandom_range(0, 2) == 0);
                bus_wren_i[n] = ($urandom_range(0, 5) == 0);
                bus_ack_i[n]  = ($urandom_range(0, 7) == 0);
                bus_err_i[n]  = ($urandom_range(0, 39) == 0);
                bus_tmo_i[n]  = ($urandom_range(0, 49) == 0);
                bus_ign_i[n]  = ($urandom_range(0, 19) == 0);
            end
            rden_i = 0; wren_i = 0; data_i = $urandom;
            r = $urandom_range(0, 7);
            if (r == 0) rden_i = 1;
            else if (r == 1) wren_i = 1;
            w = $urandom_range(0, 3);
            addr_i = ($urandom_range(0, 9) == 0) ? $urandom : haddr(w);
            if (wren_i && w == 2) data_i = $urandom_range(0, 12);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
